muldiv_hilo_unit: RTL

//  Execute-stage iterative multiply/divide unit owning the HI/LO registers.

---
 rtl/muldiv_hilo_unit.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_hilo_unit
//  Description : Iterative multiply/divide unit that owns the HI/LO registers.
//                Radix-2 shift-add multiply and restoring divide on operand
//                magnitudes, with sign correction applied in a final cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startE,
    input  logic [1:0]       opE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             abortE,
    input  logic             hlwriteW,
    input  logic             hlselW,
    input  logic [WIDTH-1:0] hlwdataW,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [c_CNT_W-1:0]   count_q, count_d;
    // Multiply: {partial product high, multiplier/product low}
    // Divide  : {partial remainder, dividend/quotient}
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;     // |multiplicand| or |divisor|
    logic [WIDTH-1:0]     araw_q, araw_d;     // raw dividend for divide-by-zero
    logic                 is_div_q, is_div_d;
    logic                 divz_q, divz_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 w_signed, w_a_neg, w_b_neg;
    logic [WIDTH-1:0]     w_abs_a, w_abs_b;
    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH:0]       w_rem_new;
    logic                 w_ge;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Operand magnitudes, one iteration step of each algorithm, and sign fix-up
    always_comb begin
        w_signed  = ~opE[0];
        w_a_neg   = w_signed & srcaE[WIDTH-1];
        w_b_neg   = w_signed & srcbE[WIDTH-1];
        w_abs_a   = w_a_neg ? (-srcaE) : srcaE;
        w_abs_b   = w_b_neg ? (-srcbE) : srcbE;

        w_mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, opnd_q} : '0);

        // Remainder is always below the divisor, so the shifted value fits WIDTH+1 bits
        w_rem_sh  = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        w_ge      = (w_rem_sh >= {1'b0, opnd_q});
        w_rem_new = w_ge ? (w_rem_sh - {1'b0, opnd_q}) : w_rem_sh;

        w_prod    = neg_res_q ? (-p_q) : p_q;
        w_quot    = neg_res_q ? (-p_q[WIDTH-1:0]) : p_q[WIDTH-1:0];
        w_rem     = neg_rem_q ? (-p_q[2*WIDTH-1:WIDTH]) : p_q[2*WIDTH-1:WIDTH];
    end

    // Next-state logic for the IDLE -> RUN -> FIN sequence and HI/LO writes
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        p_d       = p_q;
        opnd_d    = opnd_q;
        araw_d    = araw_q;
        is_div_d  = is_div_q;
        divz_d    = divz_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            S_IDLE: begin
                if (hlwriteW) begin
                    if (hlselW) hi_d = hlwdataW;
                    else        lo_d = hlwdataW;
                end
                if (startE && !abortE) begin
                    is_div_d  = opE[1];
                    divz_d    = opE[1] && (srcbE == '0);
                    araw_d    = srcaE;
                    neg_res_d = w_a_neg ^ w_b_neg;
                    neg_rem_d = w_a_neg;
                    opnd_d    = opE[1] ? w_abs_b : w_abs_a;
                    p_d       = {{WIDTH{1'b0}}, (opE[1] ? w_abs_a : w_abs_b)};
                    count_d   = '0;
                    busy_d    = 1'b1;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (is_div_q) p_d = {w_rem_new[WIDTH-1:0], p_q[WIDTH-2:0], w_ge};
                else          p_d = {w_mul_sum, p_q[WIDTH-1:1]};
                count_d = count_q + 1'b1;
                if (count_q == c_CNT_W'(WIDTH - 1)) state_d = S_FIN;
            end
            S_FIN: begin
                if (divz_q) begin
                    hi_d = araw_q;
                    lo_d = '1;
                end else if (is_div_q) begin
                    hi_d = w_rem;
                    lo_d = w_quot;
                end else begin
                    {hi_d, lo_d} = w_prod;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // A flushed instruction cancels the op; results from FIN are discarded too
        if (abortE && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            p_q       <= '0;
            opnd_q    <= '0;
            araw_q    <= '0;
            is_div_q  <= 1'b0;
            divz_q    <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            p_q       <= p_d;
            opnd_q    <= opnd_d;
            araw_q    <= araw_d;
            is_div_q  <= is_div_d;
            divz_q    <= divz_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule
`default_nettype wire
